// File: rtl/vga_trace_plotter.sv
// VGA timing generator with CHANNELS fixed-point line traces y = slope*x + offset.
// Define VGA_TRACE_GRID_EN to draw a half-intensity 64-pixel grid behind the traces.
module vga_trace_plotter #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int PIX_DIV   = 2,
    parameter int CHANNELS  = 4,
    parameter int DATA_W    = 16,
    parameter int FRAC_W    = 4,
    parameter int COLOR_W   = 3,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic               clk50,
    input  logic               rst_n,
    input  logic               cfg_wr,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic               cfg_en,
    input  logic [DATA_W-1:0]  cfg_slope,
    input  logic [DATA_W-1:0]  cfg_offset,
    input  logic [COLOR_W-1:0] cfg_color,
    output logic               cfg_pending,
    output logic               frame_start,
    output logic [COLOR_W-1:0] pixel,
    output logic               hsync,
    output logic               vsync
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int X_W     = ($clog2(H_TOTAL) > 6) ? $clog2(H_TOTAL) : 6;
    localparam int Y_W     = ($clog2(V_TOTAL) > 6) ? $clog2(V_TOTAL) : 6;
    localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int ACC_W   = DATA_W + 11;

    localparam logic [X_W-1:0]   X_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]   X_VIS    = X_W'(H_VISIBLE);
    localparam logic [X_W-1:0]   HS_BEG   = X_W'(H_VISIBLE + H_FRONT);
    localparam logic [X_W-1:0]   HS_END   = X_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]   Y_VIS    = Y_W'(V_VISIBLE);
    localparam logic [Y_W-1:0]   VS_BEG   = Y_W'(V_VISIBLE + V_FRONT);
    localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);

    typedef struct packed {
        logic               en;
        logic [DATA_W-1:0]  slope;
        logic [DATA_W-1:0]  offset;
        logic [COLOR_W-1:0] color;
    } chan_t;

    function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] v);
        return {{(ACC_W - DATA_W){v[DATA_W-1]}}, v};
    endfunction

    chan_t                    shd_r [CHANNELS];
    chan_t                    act_r [CHANNELS];
    logic signed [ACC_W-1:0]  acc_r [CHANNELS];
    logic [DIV_W-1:0]         div_r;
    logic [X_W-1:0]           x_r;
    logic [Y_W-1:0]           y_r;
    logic [COLOR_W-1:0]       color1_r;
    logic                     hs1_r;
    logic                     vs1_r;
    logic                     pix_ce_s;
    logic                     commit_s;
    logic                     wr_ok_s;
    logic [CHANNELS-1:0]      hit_s;
    logic                     hit_any_s;
    logic [COLOR_W-1:0]       color_s;
    logic [COLOR_W-1:0]       pix_next_s;
    logic                     vis_s;

    assign pix_ce_s = (div_r == DIV_LAST);
    assign commit_s = pix_ce_s && (x_r == X_LAST) && (y_r == Y_LAST);
    assign wr_ok_s  = cfg_wr && ({1'b0, cfg_ch} < (CH_W + 1)'(CHANNELS));
    assign vis_s    = (x_r < X_VIS) && (y_r < Y_VIS);

    // pixel-tick divider
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= {DIV_W{1'b0}};
        end else if (pix_ce_s) begin
            div_r <= {DIV_W{1'b0}};
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // raster position counters (stage 0)
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= {X_W{1'b0}};
            y_r <= {Y_W{1'b0}};
        end else if (pix_ce_s) begin
            if (x_r == X_LAST) begin
                x_r <= {X_W{1'b0}};
                y_r <= (y_r == Y_LAST) ? {Y_W{1'b0}} : y_r + Y_W'(1);
            end else begin
                x_r <= x_r + X_W'(1);
            end
        end
    end

    // shadow/active channel settings; a write on the commit cycle lands in shadow only
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shd_r[i] <= '0;
                act_r[i] <= '0;
            end
            cfg_pending <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_ok_s && (cfg_ch == CH_W'(i))) begin
                    shd_r[i] <= '{en: cfg_en, slope: cfg_slope, offset: cfg_offset, color: cfg_color};
                end
                if (commit_s) begin
                    act_r[i] <= shd_r[i];
                end
            end
            frame_start <= commit_s;
            cfg_pending <= wr_ok_s ? 1'b1 : (commit_s ? 1'b0 : cfg_pending);
        end
    end

    // per-channel accumulators track offset + slope*x alongside the counters
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc_r[i] <= {ACC_W{1'b0}};
            end
        end else if (pix_ce_s) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (x_r == X_LAST) begin
                    acc_r[i] <= sext(commit_s ? shd_r[i].offset : act_r[i].offset);
                end else if (x_r < X_VIS) begin
                    acc_r[i] <= acc_r[i] + sext(act_r[i].slope);
                end
            end
        end
    end

    // hit detection; a non-negative acc lets the integer part be compared directly
    always_comb begin
        hit_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            hit_s[i] = act_r[i].en && !acc_r[i][ACC_W-1] &&
                       (acc_r[i][ACC_W-1:FRAC_W] == {{(ACC_W - FRAC_W - Y_W){1'b0}}, y_r});
        end
    end

    // priority select: scanning downwards leaves the lowest hitting index
    always_comb begin
        color_s   = {COLOR_W{1'b0}};
        hit_any_s = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (hit_s[i]) begin
                color_s   = act_r[i].color;
                hit_any_s = 1'b1;
            end else begin
                color_s   = color_s;
                hit_any_s = hit_any_s;
            end
        end
    end

    // background and visibility masking
    always_comb begin
        pix_next_s = {COLOR_W{1'b0}};
        if (!vis_s) begin
            pix_next_s = {COLOR_W{1'b0}};
        end else if (hit_any_s) begin
            pix_next_s = color_s;
`ifdef VGA_TRACE_GRID_EN
        end else if ((x_r[5:0] == 6'd0) || (y_r[5:0] == 6'd0)) begin
            pix_next_s = {1'b0, {(COLOR_W - 1){1'b1}}};
`endif
        end else begin
            pix_next_s = {COLOR_W{1'b0}};
        end
    end

    // stage 1 and stage 2 registers; syncs share the pixel's delay
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            color1_r <= {COLOR_W{1'b0}};
            hs1_r    <= 1'b1;
            vs1_r    <= 1'b1;
            pixel    <= {COLOR_W{1'b0}};
            hsync    <= 1'b1;
            vsync    <= 1'b1;
        end else if (pix_ce_s) begin
            color1_r <= pix_next_s;
            hs1_r    <= !((x_r >= HS_BEG) && (x_r < HS_END));
            vs1_r    <= !((y_r >= VS_BEG) && (y_r < VS_END));
            pixel    <= color1_r;
            hsync    <= hs1_r;
            vsync    <= vs1_r;
        end
    end
endmodule

// File: tb/tb_vga_trace_plotter.sv
// Directed bench for vga_trace_plotter using a reduced 48x34 raster to keep frames short.
module tb_vga_trace_plotter;
    localparam int HT = 48;
    localparam int VT = 34;

    logic       clk50;
    logic       rst_n;
    logic       cfg_wr;
    logic [1:0] cfg_ch;
    logic       cfg_en;
    logic [15:0] cfg_slope;
    logic [15:0] cfg_offset;
    logic [2:0] cfg_color;
    logic       cfg_pending;
    logic       frame_start;
    logic [2:0] pixel;
    logic       hsync;
    logic       vsync;

    int checks = 0;
    int errors = 0;

    vga_trace_plotter #(
        .H_VISIBLE(40), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(30), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIX_DIV(2), .CHANNELS(4), .DATA_W(16), .FRAC_W(4), .COLOR_W(3)
    ) dut (
        .clk50(clk50), .rst_n(rst_n), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
        .cfg_en(cfg_en), .cfg_slope(cfg_slope), .cfg_offset(cfg_offset),
        .cfg_color(cfg_color), .cfg_pending(cfg_pending), .frame_start(frame_start),
        .pixel(pixel), .hsync(hsync), .vsync(vsync)
    );

    initial begin
        clk50 = 1'b0;
        forever #5 clk50 = ~clk50;
    end

    // reference raster position: counters plus the two-tick output lag
    int bdiv, bx, by, px, py, ox, oy;
    always @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            bdiv <= 0; bx <= 0; by <= 0; px <= 0; py <= 0; ox <= 0; oy <= 0;
        end else if (bdiv == 1) begin
            bdiv <= 0;
            px <= bx; py <= by; ox <= px; oy <= py;
            if (bx == HT - 1) begin
                bx <= 0;
                by <= (by == VT - 1) ? 0 : by + 1;
            end else begin
                bx <= bx + 1;
            end
        end else begin
            bdiv <= 1;
        end
    end

    typedef struct {
        int         ph;
        int         x;
        int         y;
        logic [2:0] pix;
        logic       hs;
        logic       vs;
    } vec_t;
    vec_t tbl[$];

    function automatic logic [2:0] bg(input int x, input int y);
`ifdef VGA_TRACE_GRID_EN
        if (x < 40 && y < 30 && (x % 64 == 0 || y % 64 == 0)) return 3'd3;
        else return 3'd0;
`else
        return 3'd0;
`endif
    endfunction

    function automatic vec_t mk(input int ph, input int x, input int y, input logic [2:0] pix,
                                input logic hs, input logic vs);
        vec_t v;
        v.ph = ph; v.x = x; v.y = y; v.pix = pix; v.hs = hs; v.vs = vs;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic goto(input int x, input int y);
        int n;
        n = 0;
        do begin
            @(negedge clk50);
            n++;
        end while (!(ox == x && oy == y && bdiv == 0) && n < 8000);
        if (n >= 8000) begin
            checks++; errors++;
            $display("FAIL goto_timeout pos=%0d,%0d", x, y);
        end
    endtask

    task automatic wait_commit(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk50);
            n++;
        end while (frame_start !== 1'b1 && n < 8000);
        chk(name, frame_start, 1'b1);
    endtask

    task automatic wr(input int ch, input logic en, input logic [15:0] sl,
                      input logic [15:0] off, input logic [2:0] col);
        @(negedge clk50);
        cfg_wr = 1'b1; cfg_ch = 2'(ch); cfg_en = en;
        cfg_slope = sl; cfg_offset = off; cfg_color = col;
        @(negedge clk50);
        cfg_wr = 1'b0;
    endtask

    task automatic run_phase(input int p);
        foreach (tbl[i]) begin
            if (tbl[i].ph == p) begin
                goto(tbl[i].x, tbl[i].y);
                chk($sformatf("p%0d_pix_%0d_%0d", p, tbl[i].x, tbl[i].y), pixel, tbl[i].pix);
                chk($sformatf("p%0d_hs_%0d_%0d", p, tbl[i].x, tbl[i].y), hsync, tbl[i].hs);
                chk($sformatf("p%0d_vs_%0d_%0d", p, tbl[i].x, tbl[i].y), vsync, tbl[i].vs);
            end
        end
    endtask

    initial begin
        int cnt;
        // phase 1: idle raster, sync windows x in [42,46), y in [31,33)
        tbl.push_back(mk(1, 5, 3, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(1, 41, 3, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(1, 42, 3, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1, 45, 3, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(1, 46, 3, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(1, 10, 30, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(1, 10, 31, 3'd0, 1'b1, 1'b0));
        tbl.push_back(mk(1, 44, 32, 3'd0, 1'b0, 1'b0));
        tbl.push_back(mk(1, 10, 33, 3'd0, 1'b1, 1'b1));
        // phase 2: ch0 y=2x colour 5
        tbl.push_back(mk(2, 0, 0, 3'd5, 1'b1, 1'b1));
        tbl.push_back(mk(2, 5, 0, bg(5, 0), 1'b1, 1'b1));
        tbl.push_back(mk(2, 5, 10, 3'd5, 1'b1, 1'b1));
        tbl.push_back(mk(2, 5, 11, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(2, 6, 12, 3'd5, 1'b1, 1'b1));
        tbl.push_back(mk(2, 14, 28, 3'd5, 1'b1, 1'b1));
        tbl.push_back(mk(2, 15, 29, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(2, 15, 30, 3'd0, 1'b1, 1'b1));
        // phase 3: ch0,ch1 y=x (colours 1,2), ch2 y=x+5 colour 6
        tbl.push_back(mk(3, 0, 0, 3'd1, 1'b1, 1'b1));
        tbl.push_back(mk(3, 0, 5, 3'd6, 1'b1, 1'b1));
        tbl.push_back(mk(3, 3, 7, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(3, 7, 7, 3'd1, 1'b1, 1'b1));
        tbl.push_back(mk(3, 3, 8, 3'd6, 1'b1, 1'b1));
        tbl.push_back(mk(3, 8, 8, 3'd1, 1'b1, 1'b1));
        tbl.push_back(mk(3, 20, 25, 3'd6, 1'b1, 1'b1));
        // phase 4: ch0 slope 0.5 offset -16 colour 7, others off
        tbl.push_back(mk(4, 16, 0, bg(16, 0), 1'b1, 1'b1));
        tbl.push_back(mk(4, 31, 0, bg(31, 0), 1'b1, 1'b1));
        tbl.push_back(mk(4, 32, 0, 3'd7, 1'b1, 1'b1));
        tbl.push_back(mk(4, 33, 0, 3'd7, 1'b1, 1'b1));
        tbl.push_back(mk(4, 34, 0, bg(34, 0), 1'b1, 1'b1));
        tbl.push_back(mk(4, 34, 1, 3'd7, 1'b1, 1'b1));
        tbl.push_back(mk(4, 35, 1, 3'd7, 1'b1, 1'b1));
        tbl.push_back(mk(4, 36, 2, 3'd7, 1'b1, 1'b1));
        tbl.push_back(mk(4, 39, 3, 3'd7, 1'b1, 1'b1));
        tbl.push_back(mk(4, 40, 4, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(4, 41, 4, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(4, 7, 7, 3'd0, 1'b1, 1'b1));
        // phase 5: frame right after a commit-cycle write still shows the old set
        tbl.push_back(mk(5, 39, 3, 3'd7, 1'b1, 1'b1));
        tbl.push_back(mk(5, 10, 20, 3'd0, 1'b1, 1'b1));
        // phase 6: ch3 horizontal line y=20 colour 4
        tbl.push_back(mk(6, 0, 20, 3'd4, 1'b1, 1'b1));
        tbl.push_back(mk(6, 10, 20, 3'd4, 1'b1, 1'b1));
        tbl.push_back(mk(6, 39, 20, 3'd4, 1'b1, 1'b1));
        tbl.push_back(mk(6, 40, 20, 3'd0, 1'b1, 1'b1));
        // phase 7: after mid-frame reset everything is cleared and timing restarts
        tbl.push_back(mk(7, 20, 0, bg(20, 0), 1'b1, 1'b1));
        tbl.push_back(mk(7, 43, 0, 3'd0, 1'b0, 1'b1));
        tbl.push_back(mk(7, 10, 20, 3'd0, 1'b1, 1'b1));
        tbl.push_back(mk(7, 5, 31, 3'd0, 1'b1, 1'b0));

        rst_n = 1'b0; cfg_wr = 1'b0; cfg_ch = 2'd0; cfg_en = 1'b0;
        cfg_slope = 16'h0000; cfg_offset = 16'h0000; cfg_color = 3'd0;
        #23;
        chk("rst_pixel", pixel, 3'd0);
        chk("rst_hsync", hsync, 1'b1);
        chk("rst_vsync", vsync, 1'b1);
        chk("rst_pending", cfg_pending, 1'b0);
        chk("rst_frame_start", frame_start, 1'b0);
        @(negedge clk50);
        rst_n = 1'b1;

        cnt = 0;
        for (int i = 0; i < HT; i++) begin
            goto(i, 5);
            if (hsync === 1'b0) cnt++;
            chk($sformatf("idle_pix_%0d_5", i), pixel, 3'd0);
        end
        chk("hsync_low_ticks", cnt, 4);
        cnt = 0;
        for (int j = 0; j < VT; j++) begin
            goto(0, j);
            if (vsync === 1'b0) cnt++;
        end
        chk("vsync_low_lines", cnt, 2);
        run_phase(1);

        goto(2, 4);
        wr(0, 1'b1, 16'h0020, 16'h0000, 3'd5);
        chk("pending_after_wr", cfg_pending, 1'b1);
        goto(5, 10);
        chk("old_frame_pix_5_10", pixel, 3'd0);
        chk("pending_mid_frame", cfg_pending, 1'b1);
        wait_commit("commit_p2");
        chk("pending_cleared", cfg_pending, 1'b0);
        @(negedge clk50);
        chk("frame_start_width", frame_start, 1'b0);
        run_phase(2);

        wr(0, 1'b1, 16'h0010, 16'h0000, 3'd1);
        wr(1, 1'b1, 16'h0010, 16'h0000, 3'd2);
        wr(2, 1'b1, 16'h0010, 16'h0050, 3'd6);
        wait_commit("commit_p3");
        run_phase(3);

        wr(0, 1'b1, 16'h0008, 16'hFF00, 3'd7);
        wr(1, 1'b0, 16'h0010, 16'h0000, 3'd2);
        wr(2, 1'b0, 16'h0010, 16'h0050, 3'd6);
        wait_commit("commit_p4");
        run_phase(4);

        cnt = 0;
        while (!(bdiv == 1 && bx == HT - 1 && by == VT - 1) && cnt < 8000) begin
            @(negedge clk50);
            cnt++;
        end
        chk("reach_commit_cycle", cnt < 8000, 1'b1);
        cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_en = 1'b1;
        cfg_slope = 16'h0000; cfg_offset = 16'h0140; cfg_color = 3'd4;
        @(negedge clk50);
        cfg_wr = 1'b0;
        chk("commit_cycle_fs", frame_start, 1'b1);
        chk("commit_cycle_pending", cfg_pending, 1'b1);
        run_phase(5);
        wait_commit("commit_p6");
        chk("pending_after_p6", cfg_pending, 1'b0);
        run_phase(6);

        goto(0, 20);
        wr(3, 1'b1, 16'h0000, 16'h0140, 3'd4);
        goto(10, 20);
        chk("pre_rst_pixel", pixel, 3'd4);
        chk("pre_rst_pending", cfg_pending, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_pixel", pixel, 3'd0);
        chk("midrst_hsync", hsync, 1'b1);
        chk("midrst_vsync", vsync, 1'b1);
        chk("midrst_pending", cfg_pending, 1'b0);
        chk("midrst_frame_start", frame_start, 1'b0);
        @(negedge clk50);
        rst_n = 1'b1;
        run_phase(7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
